// File: rtl/mem_pkg.sv
// Shared definitions for the port-B memory arbiter: default widths,
// arbitration-mode codes and the requester-ID encoding.
package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select for two requesters: round-robin on last_grant,
// or fixed priority to requester 0 unless the starvation flag is raised.
module mem_arb_grant
  import mem_pkg::*;
(
  input  logic    valid0,
  input  logic    valid1,
  input  req_id_e last_grant,
  input  logic    fixed_mode,
  input  logic    starve,
  output logic    gnt0,
  output logic    gnt1
);

  // Pick at most one winner from the current valids.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case ({valid1, valid0})
      2'b01: gnt0 = 1'b1;
      2'b10: gnt1 = 1'b1;
      2'b11: begin
        if (fixed_mode) begin
          if (starve) begin
            gnt1 = 1'b1;
          end else begin
            gnt0 = 1'b1;
          end
        end else begin
          if (last_grant == REQ_CPU) begin
            gnt1 = 1'b1;
          end else begin
            gnt0 = 1'b1;
          end
        end
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares memory data port B between the CPU load/store stage and the loader/DMA,
// returning registered read data to the issuing requester one cycle later.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_we_b,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_wdata_b,
  input  logic [DATA_W-1:0] mem_rdata_b
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic       FIXED_C    = (ARB_MODE == ARB_FIXED);

  req_id_e           last_grant_q, last_grant_d;
  logic              rd_pend_q, rd_pend_d;
  req_id_e           rd_owner_q, rd_owner_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic gnt0, gnt1, starve, acc0, acc1, rvalid0, rvalid1;

  assign starve = FIXED_C && (wait_cnt_q == MAX_WAIT_C);

  mem_arb_grant u_grant (
    .valid0     (r0_valid),
    .valid1     (r1_valid),
    .last_grant (last_grant_q),
    .fixed_mode (FIXED_C),
    .starve     (starve),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  // Grants, memory drive and read return; everything is forced low during reset.
  always_comb begin
    acc0        = gnt0 & ~rst;
    acc1        = gnt1 & ~rst;
    rvalid0     = rd_pend_q & (rd_owner_q == REQ_CPU) & ~rst;
    rvalid1     = rd_pend_q & (rd_owner_q == REQ_LDR) & ~rst;
    r0_ready    = acc0;
    r1_ready    = acc1;
    r0_rvalid   = rvalid0;
    r1_rvalid   = rvalid1;
    mem_we_b    = 1'b0;
    mem_addr_b  = {ADDR_W{1'b0}};
    mem_wdata_b = {DATA_W{1'b0}};
    if (acc0) begin
      mem_we_b    = r0_we;
      mem_addr_b  = r0_addr;
      mem_wdata_b = r0_wdata;
    end else if (acc1) begin
      mem_we_b    = r1_we;
      mem_addr_b  = r1_addr;
      mem_wdata_b = r1_wdata;
    end else begin
      mem_we_b    = 1'b0;
    end
    if (rst) begin
      r0_rdata = {DATA_W{1'b0}};
      r1_rdata = {DATA_W{1'b0}};
    end else begin
      r0_rdata = rvalid0 ? mem_rdata_b : rdata0_q;
      r1_rdata = rvalid1 ? mem_rdata_b : rdata1_q;
    end
  end

  // Next-state for arbitration history, read tracking and starvation counter.
  always_comb begin
    last_grant_d = last_grant_q;
    rd_owner_d   = rd_owner_q;
    rd_pend_d    = (acc0 & ~r0_we) | (acc1 & ~r1_we);
    wait_cnt_d   = wait_cnt_q;
    rdata0_d     = rvalid0 ? mem_rdata_b : rdata0_q;
    rdata1_d     = rvalid1 ? mem_rdata_b : rdata1_q;
    if (acc0) begin
      last_grant_d = REQ_CPU;
      rd_owner_d   = REQ_CPU;
    end else if (acc1) begin
      last_grant_d = REQ_LDR;
      rd_owner_d   = REQ_LDR;
    end else begin
      last_grant_d = last_grant_q;
    end
    // r1 stalls accumulate only while it keeps asking and losing
    if (!r1_valid || acc1) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_CPU;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= REQ_CPU;
      wait_cnt_q   <= 4'd0;
      rdata0_q     <= {DATA_W{1'b0}};
      rdata1_q     <= {DATA_W{1'b0}};
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      wait_cnt_q   <= wait_cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin instance with a behavioural memory, and a
// fixed-priority instance used to observe the starvation-guard grant pattern.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Round-robin instance
  logic       r0_valid, r0_we, r1_valid, r1_we;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic       r0_ready, r0_rvalid, r1_ready, r1_rvalid;
  logic [7:0] r0_rdata, r1_rdata;
  logic       mem_we_b;
  logic [7:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [7:0] mem [256];

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(0), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_wdata_b(mem_wdata_b),
    .mem_rdata_b(mem_rdata_b)
  );

  // Synchronous memory: write-then-read across consecutive cycles
  always @(posedge clk) begin
    if (mem_we_b) mem[mem_addr_b] <= mem_wdata_b;
    mem_rdata_b <= mem[mem_addr_b];
  end

  // Fixed-priority instance
  logic       f0_valid, f1_valid;
  logic       f0_ready, f0_rvalid, f1_ready, f1_rvalid;
  logic [7:0] f0_rdata, f1_rdata;
  logic       f_mem_we;
  logic [7:0] f_mem_addr, f_mem_wdata;
  logic [7:0] f_mem_rdata;
  assign f_mem_rdata = 8'h00;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(1), .MAX_WAIT(4)) dut_fp (
    .clk(clk), .rst(rst),
    .r0_valid(f0_valid), .r0_we(1'b0), .r0_addr(8'd1), .r0_wdata(8'h00),
    .r0_ready(f0_ready), .r0_rvalid(f0_rvalid), .r0_rdata(f0_rdata),
    .r1_valid(f1_valid), .r1_we(1'b0), .r1_addr(8'd2), .r1_wdata(8'h00),
    .r1_ready(f1_ready), .r1_rvalid(f1_rvalid), .r1_rdata(f1_rdata),
    .mem_we_b(f_mem_we), .mem_addr_b(f_mem_addr), .mem_wdata_b(f_mem_wdata),
    .mem_rdata_b(f_mem_rdata)
  );

  task automatic drive0(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive0(1'b1, 1'b0, 8'd3, 8'h00);
    drive1(1'b1, 1'b0, 8'd4, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_we_b} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_ctrl cyc%0d: got %b expected 00000", i, {r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_we_b});
      end
      n_checks++;
      if ({mem_addr_b, mem_wdata_b, r0_rdata, r1_rdata} !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_data cyc%0d: got %h expected 0", i, {mem_addr_b, mem_wdata_b, r0_rdata, r1_rdata});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive0(1'b1, 1'b1, 8'd5, 8'hAA);
    drive1(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    n_checks++;
    if ({r0_ready, mem_we_b, mem_addr_b, mem_wdata_b} !== {1'b1, 1'b1, 8'd5, 8'hAA}) begin
      n_fail++;
      $display("FAIL first_write: got %h expected %h", {r0_ready, mem_we_b, mem_addr_b, mem_wdata_b}, {1'b1, 1'b1, 8'd5, 8'hAA});
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    drive0(1'b1, 1'b0, 8'd5, 8'h00);
    #1;
    n_checks++;
    if ({r0_ready, mem_we_b, mem_addr_b} !== {1'b1, 1'b0, 8'd5}) begin
      n_fail++;
      $display("FAIL read_accept: got %h expected %h", {r0_ready, mem_we_b, mem_addr_b}, {1'b1, 1'b0, 8'd5});
    end
    @(negedge clk);
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    n_checks++;
    if ({r0_rvalid, r1_rvalid, r0_rdata} !== {1'b1, 1'b0, 8'hAA}) begin
      n_fail++;
      $display("FAIL read_return: got %h expected %h", {r0_rvalid, r1_rvalid, r0_rdata}, {1'b1, 1'b0, 8'hAA});
    end
    @(negedge clk); #1;
    n_checks++;
    if ({r0_rvalid, r0_rdata, r0_ready} !== {1'b0, 8'hAA, 1'b0}) begin
      n_fail++;
      $display("FAIL rdata_hold: got %h expected %h", {r0_rvalid, r0_rdata, r0_ready}, {1'b0, 8'hAA, 1'b0});
    end
  endtask

  task automatic test_round_robin();
    logic exp0;
    @(negedge clk);
    drive0(1'b1, 1'b1, 8'd10, 8'h33);
    @(negedge clk);
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    drive1(1'b1, 1'b1, 8'd20, 8'hF0);
    #1;
    n_checks++;
    if ({r1_ready, r0_ready, mem_we_b} !== 3'b101) begin
      n_fail++;
      $display("FAIL preload_r1: got %b expected 101", {r1_ready, r0_ready, mem_we_b});
    end
    @(negedge clk);
    drive0(1'b1, 1'b0, 8'd10, 8'h00);
    drive1(1'b1, 1'b0, 8'd20, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp0 = ((i % 2) == 0);
      n_checks++;
      if ({r0_ready, r1_ready, mem_addr_b} !== {exp0, ~exp0, (exp0 ? 8'd10 : 8'd20)}) begin
        n_fail++;
        $display("FAIL rr_grant cyc%0d: got %h expected %h", i, {r0_ready, r1_ready, mem_addr_b}, {exp0, ~exp0, (exp0 ? 8'd10 : 8'd20)});
      end
      if (i > 0) begin
        n_checks++;
        if ({r0_rvalid, r1_rvalid, (exp0 ? r1_rdata : r0_rdata)} !== {~exp0, exp0, (exp0 ? 8'hF0 : 8'h33)}) begin
          n_fail++;
          $display("FAIL rr_rdata cyc%0d: got %h expected %h", i, {r0_rvalid, r1_rvalid, (exp0 ? r1_rdata : r0_rdata)}, {~exp0, exp0, (exp0 ? 8'hF0 : 8'h33)});
        end
      end
    end
    @(negedge clk);
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    drive1(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    n_checks++;
    if ({r0_rvalid, r1_rvalid, r1_rdata, r0_rdata} !== {1'b0, 1'b1, 8'hF0, 8'h33}) begin
      n_fail++;
      $display("FAIL rr_last_return: got %h expected %h", {r0_rvalid, r1_rvalid, r1_rdata, r0_rdata}, {1'b0, 1'b1, 8'hF0, 8'h33});
    end
  endtask

  task automatic test_starvation_guard();
    logic exp1;
    @(negedge clk);
    f0_valid = 1'b1;
    f1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp1 = ((i % 5) == 4);
      n_checks++;
      if ({f0_ready, f1_ready, f_mem_addr} !== {~exp1, exp1, (exp1 ? 8'd2 : 8'd1)}) begin
        n_fail++;
        $display("FAIL fp_grant cyc%0d: got %h expected %h", i, {f0_ready, f1_ready, f_mem_addr}, {~exp1, exp1, (exp1 ? 8'd2 : 8'd1)});
      end
    end
    @(negedge clk);
    f0_valid = 1'b0;
    f1_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive1(1'b1, 1'b1, 8'd5, 8'h55);
    #1;
    n_checks++;
    if ({r1_ready, mem_we_b, mem_addr_b, mem_wdata_b} !== {1'b1, 1'b1, 8'd5, 8'h55}) begin
      n_fail++;
      $display("FAIL b2b_write: got %h expected %h", {r1_ready, mem_we_b, mem_addr_b, mem_wdata_b}, {1'b1, 1'b1, 8'd5, 8'h55});
    end
    @(negedge clk);
    drive1(1'b0, 1'b0, 8'd0, 8'h00);
    drive0(1'b1, 1'b0, 8'd5, 8'h00);
    #1;
    n_checks++;
    if ({r0_ready, mem_we_b, r1_rvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_read: got %b expected 100", {r0_ready, mem_we_b, r1_rvalid});
    end
    @(negedge clk);
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    n_checks++;
    if ({r0_rvalid, r0_rdata, mem_we_b} !== {1'b1, 8'h55, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_return: got %h expected %h", {r0_rvalid, r0_rdata, mem_we_b}, {1'b1, 8'h55, 1'b0});
    end
  endtask

  task automatic test_mid_read_reset();
    @(negedge clk);
    drive0(1'b1, 1'b0, 8'd5, 8'h00);
    #1;
    n_checks++;
    if (r0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst_accept: got %b expected 1", r0_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    n_checks++;
    if ({r0_rvalid, r0_rdata} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_rst_during: got %h expected 000", {r0_rvalid, r0_rdata});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({r0_rvalid, r1_rvalid, r0_rdata} !== {1'b0, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL mid_rst_after cyc%0d: got %h expected 000", i, {r0_rvalid, r1_rvalid, r0_rdata});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    f0_valid = 1'b0;
    f1_valid = 1'b0;
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    drive1(1'b0, 1'b0, 8'd0, 8'h00);
    test_reset();
    test_single_read();
    test_round_robin();
    test_starvation_guard();
    test_back_to_back();
    test_mid_read_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data port (port B) of the dual-port instruction/data memory between two requesters.
- Requester 0 is the CPU load/store stage. Requester 1 is the program loader / debug DMA.
- Issues at most one access per cycle with a valid/ready handshake.
- Routes synchronous read data back to the requester that issued the read, one cycle later, so back-to-back accesses run at full throughput.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority to requester 0 with starvation guard
- MAX_WAIT, 4, in ARB_MODE=1, consecutive stalled cycles of requester 1 before it is forced a grant (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- r0_valid  in  1  requester 0 access request
- r0_we  in  1  1 = write, 0 = read
- r0_addr  in  ADDR_W  access address
- r0_wdata  in  DATA_W  write data
- r0_ready  out  1  grant; access is accepted in a cycle where r0_valid & r0_ready
- r0_rvalid  out  1  read data valid for requester 0
- r0_rdata  out  DATA_W  read data for requester 0
- r1_valid, r1_we, r1_addr, r1_wdata, r1_ready, r1_rvalid, r1_rdata: same as the r0_* ports, for requester 1
- mem_we_b  out  1  to memory we_b
- mem_addr_b  out  ADDR_W  to memory addr_b
- mem_wdata_b  out  DATA_W  to memory write_data_b
- mem_rdata_b  in  DATA_W  from memory data_out_b (registered by memory)

Behaviour:
- Clock and reset: one clock domain. rst is synchronous and active-high.
- While rst=1, all outputs are 0:
  - rN_ready=0, rN_rvalid=0, rN_rdata=0
  - mem_we_b=0, mem_addr_b=0, mem_wdata_b=0
- Reset clears these state bits to 0: last_grant, rd_pend, rd_owner, wait_cnt.
- Grant generation is combinational from rN_valid and the registered state. At most one of r0_ready and r1_ready is 1 in any cycle.
- rN_ready=0 whenever rN_valid=0. There is no speculative grant.
- Memory drive is combinational:
  - Granted requester's we/addr/wdata drive mem_*_b.
  - No grant: mem_we_b=0, mem_addr_b=0, mem_wdata_b=0.
- Round-robin (ARB_MODE=0):
  - Only one requester valid: it is granted.
  - Both valid: grant the requester != last_grant.
  - last_grant updates on every accepted access.
- Fixed priority (ARB_MODE=1):
  - r0 wins ties unless wait_cnt == MAX_WAIT; then r1 wins.
  - wait_cnt increments, saturating at MAX_WAIT, each cycle r1_valid=1 and r1 is not granted.
  - wait_cnt clears on an r1 grant or when r1_valid=0.
- Read return:
  - A read accepted in cycle N sets rd_pend=1 and rd_owner=N at the edge ending cycle N.
  - In cycle N+1: r<owner>_rvalid=1 and r<owner>_rdata=mem_rdata_b.
  - rvalid is a single-cycle pulse. rdata holds its last value when rvalid=0.
- Writes produce no rvalid. Completion is the accept cycle itself.
- A new access may be accepted in cycle N+1 while the read data from N is returned. There are no bubbles.
- Read from an address written in the previous cycle returns the new data (memory write-then-read ordering). The arbiter adds no forwarding.
- Holding: the requester must keep valid/we/addr/wdata stable until accepted. The arbiter does not check this.
- rst asserted mid-operation: a pending read is dropped and no rvalid follows the reset cycle.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W and DATA_W defaults
  - ARB_RR=0 and ARB_FIXED=1 constants
  - the requester-ID encoding (REQ_CPU=0, REQ_LDR=1)
- One natural sub-module, mem_arb_grant: a combinational grant-select function of valids, last_grant and starvation flag. Everything else is flat in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both requesters valid → all ready/rvalid/mem_we_b are 0. After release, with r0 writing 0xAA to 5, mem_we_b=1 and mem_addr_b=5 in the first cycle.
- Single requester read: r0 writes 0xAA@5, then reads @5 the next cycle → r0_rvalid=1 with r0_rdata=0xAA exactly one cycle after the read accept; r1_rvalid stays 0.
- Round-robin contention, ARB_MODE=0: both requesters continuously read (r0@10 = 0x33, r1@20 = 0xF0 preloaded) → grants alternate r0,r1,r0,r1. rvalid alternates with the matching data 0x33 / 0xF0 one cycle behind each grant.
- Starvation guard, ARB_MODE=1, MAX_WAIT=4: r0 and r1 continuously valid → r1 is granted on the 5th cycle. Pattern r0×4, r1, repeats.
- Back-to-back mixed: r1 writes 0x55@5 in cycle N, r0 reads @5 in N+1 → r0_rdata=0x55 in N+2. mem_we_b=1 only in cycle N.
- Mid-read reset: r0 read accepted, rst=1 in the next cycle → r0_rvalid stays 0 throughout and after reset.
